// File: rtl/uart_feedback_decoder_pkg.sv
// Shared constants and types for the GenshinKitchen feedback decoder.
package feedback_pkg;

  localparam logic [1:0] CH_FEEDBACK = 2'b01;

  localparam int unsigned FLAG_TF_POS = 2;  // traveler_in_front
  localparam int unsigned FLAG_TH_POS = 3;  // traveler_has_item
  localparam int unsigned FLAG_MP_POS = 4;  // machine_processing
  localparam int unsigned FLAG_MH_POS = 5;  // machine_has_item

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

endpackage

// File: rtl/uart_feedback_decoder_valid_edge_detect.sv
// Rising-edge detector on the UART valid level; resets to 1 so a level held
// high across reset release does not count as a new byte.
module valid_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic valid_in,
  output logic rise_c
);

  logic valid_q;
  logic valid_d;

  always_comb begin
    valid_d = valid_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rise_c = valid_in & ~valid_q;

endmodule

// File: rtl/uart_feedback_decoder.sv
// Decodes UART feedback bytes into registered status flags, with link watchdog
// and frame counter. Optional repeat filter enabled by FEEDBACK_FILTER_EN.
module uart_feedback_decoder
  import feedback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15360,
  parameter int unsigned FILTER_DEPTH   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataOut_bits,
  input  logic       dataOut_valid,
  input  logic       script_mode,
  output logic       traveler_in_front,
  output logic       traveler_has_item,
  output logic       machine_processing,
  output logic       machine_has_item,
  output logic       link_up,
  output logic       update_pulse,
  output logic [7:0] frame_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             rise_c;
  logic             accept_c;
  logic             timeout_c;
  logic             load_c;
  logic [3:0]       frame_flags_c;
  logic [3:0]       load_val_c;

  link_state_e      state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic             update_q, update_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  valid_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .valid_in (dataOut_valid),
    .rise_c   (rise_c)
  );

  assign accept_c = rise_c & ~script_mode & (dataOut_bits[1:0] == CH_FEEDBACK);
  assign frame_flags_c = {dataOut_bits[FLAG_MH_POS], dataOut_bits[FLAG_MP_POS],
                          dataOut_bits[FLAG_TH_POS], dataOut_bits[FLAG_TF_POS]};
  // Timeout fires on the edge where the counter would reach its limit; accept overrides it.
  assign timeout_c = ~script_mode & ~accept_c & (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef FEEDBACK_FILTER_EN
  localparam int unsigned MATCH_W = $clog2(FILTER_DEPTH + 1);

  logic [3:0]         cand_q, cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               unused_c;

  assign unused_c = ^dataOut_bits[7:6];

  // Candidate must repeat FILTER_DEPTH times before it reaches the flags.
  always_comb begin
    cand_d     = cand_q;
    match_d    = match_q;
    load_c     = 1'b0;
    load_val_c = cand_q;
    if (accept_c) begin
      if (frame_flags_c == cand_q) begin
        if (match_q != MATCH_W'(FILTER_DEPTH)) begin
          match_d = match_q + MATCH_W'(1);
          load_c  = (match_d == MATCH_W'(FILTER_DEPTH));
        end
      end else begin
        cand_d  = frame_flags_c;
        match_d = MATCH_W'(1);
        load_c  = (FILTER_DEPTH <= 1);
      end
      load_val_c = frame_flags_c;
    end else if (timeout_c) begin
      cand_d  = '0;
      match_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q  <= '0;
      match_q <= '0;
    end else begin
      cand_q  <= cand_d;
      match_q <= match_d;
    end
  end
`else
  logic unused_c;

  assign unused_c = ^{dataOut_bits[7:6], 1'(FILTER_DEPTH)};

  always_comb begin
    load_c     = accept_c;
    load_val_c = frame_flags_c;
  end
`endif

  // Next-state for link FSM, flags, watchdog and frame counter.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    update_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    wdog_d      = wdog_q;

    if (script_mode || accept_c) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
      wdog_d = wdog_q + WD_W'(1);
    end

    if (accept_c) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (load_c) begin
      flags_d  = load_val_c;
      update_d = 1'b1;
      state_d  = LINK_UP;
    end else if (timeout_c) begin
      flags_d = '0;
      state_d = LINK_DOWN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LINK_DOWN;
      flags_q     <= '0;
      update_q    <= 1'b0;
      frame_cnt_q <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      update_q    <= update_d;
      frame_cnt_q <= frame_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  assign traveler_in_front  = flags_q[0];
  assign traveler_has_item  = flags_q[1];
  assign machine_processing = flags_q[2];
  assign machine_has_item   = flags_q[3];
  assign link_up            = (state_q == LINK_UP);
  assign update_pulse       = update_q;
  assign frame_count        = frame_cnt_q;

endmodule

// File: tb/tb_uart_feedback_decoder.sv
// Directed bench for uart_feedback_decoder (default build; FEEDBACK_FILTER_EN
// selects the filter sequence instead).
module tb_uart_feedback_decoder;

  localparam int unsigned T = 15360;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] bits;
  logic       valid;
  logic       script;
  logic       tf, th, mp, mh, link, pulse;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  uart_feedback_decoder #(.TIMEOUT_CYCLES(T), .FILTER_DEPTH(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .dataOut_bits       (bits),
    .dataOut_valid      (valid),
    .script_mode        (script),
    .traveler_in_front  (tf),
    .traveler_has_item  (th),
    .machine_processing (mp),
    .machine_has_item   (mh),
    .link_up            (link),
    .update_pulse       (pulse),
    .frame_count        (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         hold;
    logic       scr;
    int         exp_p;
    logic [3:0] exp_f;
    logic       exp_link;
    logic [7:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {mh, mp, th, tf};
  endfunction

  // Called at posedge+1; holds valid for 'hold' cycles then one low cycle.
  task automatic send(input logic [7:0] b, input int hold, output int first_p, output int pulses);
    bits = b;
    valid = 1'b1;
    pulses = 0;
    first_p = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (i == 0) first_p = int'(pulse);
      pulses += int'(pulse);
    end
    valid = 1'b0;
    @(posedge clock); #1;
    pulses += int'(pulse);
  endtask

  initial begin
    vec_t tbl[8];
    int   fp, np, tot;
    logic [7:0] exp_cnt;

    tbl[0] = '{8'h29, 3, 1'b0, 1, 4'b1010, 1'b1, 8'd1};
    tbl[1] = '{8'h3C, 1, 1'b0, 0, 4'b1010, 1'b1, 8'd1};
    tbl[2] = '{8'h3E, 2, 1'b0, 0, 4'b1010, 1'b1, 8'd1};
    tbl[3] = '{8'h3D, 1, 1'b1, 0, 4'b1010, 1'b1, 8'd1};
    tbl[4] = '{8'h15, 1, 1'b0, 1, 4'b0101, 1'b1, 8'd2};
    tbl[5] = '{8'hC5, 2, 1'b0, 1, 4'b0001, 1'b1, 8'd3};
    tbl[6] = '{8'h3F, 1, 1'b0, 0, 4'b0001, 1'b1, 8'd3};
    tbl[7] = '{8'h3D, 1, 1'b0, 1, 4'b1111, 1'b1, 8'd4};

    bits = 8'h00; valid = 1'b0; script = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_flags", 32'(flags()), 32'h0);
    chk("reset_link", 32'(link), 32'h0);
    chk("reset_pulse", 32'(pulse), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

`ifndef FEEDBACK_FILTER_EN
    for (int i = 0; i < 8; i++) begin
      script = tbl[i].scr;
      send(tbl[i].b, tbl[i].hold, fp, np);
      chk($sformatf("vec%0d_first_pulse", i), 32'(fp), 32'(tbl[i].exp_p));
      chk($sformatf("vec%0d_pulses", i), 32'(np), 32'(tbl[i].exp_p));
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tbl[i].exp_f));
      chk($sformatf("vec%0d_link", i), 32'(link), 32'(tbl[i].exp_link));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
    end
    script = 1'b0;
    exp_cnt = 8'd4;

    // Long script-mode hold: watchdog frozen, link stays up.
    script = 1'b1;
    repeat (20000) @(posedge clock);
    #1;
    chk("script_hold_link", 32'(link), 32'h1);
    chk("script_hold_flags", 32'(flags()), 32'hF);
    script = 1'b0;

    // Exact timeout after one frame.
    bits = 8'h09; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    exp_cnt++;
    chk("wd_frame_pulse", 32'(pulse), 32'h1);
    chk("wd_frame_flags", 32'(flags()), 32'h2);
    repeat (T - 1) @(posedge clock);
    #1;
    chk("wd_before_link", 32'(link), 32'h1);
    @(posedge clock); #1;
    chk("wd_at_link", 32'(link), 32'h0);
    chk("wd_at_flags", 32'(flags()), 32'h0);
    chk("wd_at_pulse", 32'(pulse), 32'h0);
    chk("wd_at_count", 32'(count), 32'(exp_cnt));

    // Frame on the timeout cycle: accept wins.
    bits = 8'h21; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    exp_cnt++;
    repeat (T - 1) @(posedge clock);
    #1;
    chk("race_before_link", 32'(link), 32'h1);
    bits = 8'h25; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    exp_cnt++;
    chk("race_link", 32'(link), 32'h1);
    chk("race_pulse", 32'(pulse), 32'h1);
    chk("race_flags", 32'(flags()), 32'h9);
    chk("race_count", 32'(count), 32'(exp_cnt));
    @(posedge clock); #1;
    chk("race_after_link", 32'(link), 32'h1);

    // 256 frames wrap the counter back to its start value.
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      send(8'h05, 1, fp, np);
      tot += np;
    end
    chk("wrap_pulses", 32'(tot), 32'd256);
    chk("wrap_count", 32'(count), 32'(exp_cnt));
`endif

    // Async reset mid-cycle with valid held high, then release: no event.
    bits = 8'h05; valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_link", 32'(link), 32'h0);
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_flags", 32'(flags()), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    tot = 0;
    repeat (3) begin
      @(posedge clock); #1;
      tot += int'(pulse);
    end
    chk("held_valid_pulses", 32'(tot), 32'h0);
    chk("held_valid_count", 32'(count), 32'h0);
    valid = 1'b0;
    @(posedge clock); #1;

`ifdef FEEDBACK_FILTER_EN
    send(8'h05, 1, fp, np);
    chk("filt_05_pulses", 32'(np), 32'h0);
    send(8'h09, 1, fp, np);
    chk("filt_09a_pulses", 32'(np), 32'h0);
    send(8'h09, 1, fp, np);
    chk("filt_09b_pulses", 32'(np), 32'h1);
    chk("filt_has_item", 32'(th), 32'h1);
    chk("filt_flags", 32'(flags()), 32'h2);
    send(8'h09, 1, fp, np);
    chk("filt_09c_pulses", 32'(np), 32'h0);
    chk("filt_count", 32'(count), 32'd4);
    chk("filt_link", 32'(link), 32'h1);
`else
    send(8'h29, 2, fp, np);
    chk("post_rst_pulses", 32'(np), 32'h1);
    chk("post_rst_flags", 32'(flags()), 32'hA);
    chk("post_rst_count", 32'(count), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
